// File: rtl/psram_read_capture.sv
// Read-data capture stage for the PSRAM burst controller: buffers one burst in a
// first-word-fall-through FIFO. Optional pattern check: PSRAM_CAP_PATTERN_CHECK_EN.
module psram_read_capture #(
  parameter int data_width      = 16,
  parameter int fifo_depth_log2 = 5,
  parameter int burst_size      = 31
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  burst_start_i,
  input  logic                  cap_valid_i,
  input  logic [data_width-1:0] cap_dat_i,
  output logic [data_width-1:0] dat_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  busy_o,
  output logic                  ovf_o,
  input  logic                  clr_i,
  output logic                  err_o
);

  localparam int depth = 2 ** fifo_depth_log2;
  localparam int cw    = fifo_depth_log2 + 1;
  localparam logic [cw-1:0] last_idx  = cw'(burst_size);
  localparam logic [cw-1:0] full_occ  = cw'(depth);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_e;

  typedef struct packed {
    logic                  last;
    logic [data_width-1:0] data;
  } entry_t;

  state_e                     state_q, state_d;
  logic [cw-1:0]              cnt_q, cnt_d;
  logic [cw-1:0]              occ_q, occ_d;
  logic [fifo_depth_log2-1:0] wr_ptr_q, wr_ptr_d;
  logic [fifo_depth_log2-1:0] rd_ptr_q, rd_ptr_d;
  logic                       ovf_q, ovf_d;
  entry_t                     mem_q [depth];

  logic   beat, final_beat, full, valid, pop, push, drop;
  entry_t head;

  assign beat       = (state_q == CAPTURE) && cap_valid_i;
  assign final_beat = beat && (cnt_q == last_idx);
  assign full       = (occ_q == full_occ);
  assign valid      = (occ_q != '0);
  assign pop        = valid && ready_i;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push       = beat && (!full || pop);
  assign drop       = beat && full && !pop;
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE:    if (burst_start_i) state_d = CAPTURE;
      CAPTURE: if (final_beat) state_d = DRAIN;
      DRAIN:   if (pop && head.last && (occ_q == cw'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Dropped beats still advance the counter so the last tag stays aligned.
    if ((state_q == IDLE) && burst_start_i) cnt_d = '0;
    else if (beat)                          cnt_d = cnt_q + cw'(1);

    unique case ({push, pop})
      2'b10:   occ_d = occ_q + cw'(1);
      2'b01:   occ_d = occ_q - cw'(1);
      default: occ_d = occ_q;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (drop)       ovf_d = 1'b1;
    else if (clr_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by occ_q and the
  // outputs are masked by valid, so stale entries are never observable.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{last: final_beat, data: cap_dat_i};
  end

  assign valid_o = valid;
  assign dat_o   = valid ? head.data : '0;
  assign last_o  = valid && head.last;
  assign busy_o  = (state_q != IDLE);
  assign ovf_o   = ovf_q;

`ifdef PSRAM_CAP_PATTERN_CHECK_EN
  // The controller writes a counting pattern, so beat k must read back as k.
  logic err_q, err_d, mismatch;

  assign mismatch = beat && (cap_dat_i != data_width'(cnt_q));

  always_comb begin
    err_d = err_q;
    if (mismatch)   err_d = 1'b1;
    else if (clr_i) err_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_psram_read_capture.sv
// Self-checking bench for psram_read_capture: behavioural scoreboard model plus
// a second, shallow instance for the overflow corner.
module tb_psram_read_capture;

  localparam int DEPTH = 32;
  localparam int BURST = 31;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters)
  logic        rst_i = 1'b1, burst_start_i = 1'b0, cap_valid_i = 1'b0;
  logic        ready_i = 1'b0, clr_i = 1'b0;
  logic [15:0] cap_dat_i = '0, dat_o;
  logic        valid_o, last_o, busy_o, ovf_o, err_o;

  psram_read_capture u_dut (
    .clk_i(clk), .rst_i(rst_i), .burst_start_i(burst_start_i),
    .cap_valid_i(cap_valid_i), .cap_dat_i(cap_dat_i), .dat_o(dat_o),
    .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o), .busy_o(busy_o),
    .ovf_o(ovf_o), .clr_i(clr_i), .err_o(err_o)
  );

  // Shallow instance: 8-entry FIFO, 16-beat bursts
  logic        o_rst = 1'b1, o_bs = 1'b0, o_cv = 1'b0, o_rdy = 1'b0, o_clr = 1'b0;
  logic [15:0] o_cd = '0, o_dat;
  logic        o_valid, o_last, o_busy, o_ovf, o_err;

  psram_read_capture #(.data_width(16), .fifo_depth_log2(3), .burst_size(15)) u_ovf (
    .clk_i(clk), .rst_i(o_rst), .burst_start_i(o_bs),
    .cap_valid_i(o_cv), .cap_dat_i(o_cd), .dat_o(o_dat),
    .valid_o(o_valid), .ready_i(o_rdy), .last_o(o_last), .busy_o(o_busy),
    .ovf_o(o_ovf), .clr_i(o_clr), .err_o(o_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model
  typedef struct {
    logic [15:0] data;
    bit          last;
  } sb_t;

  sb_t sb[$];
  int  m_state = 0;  // 0 idle, 1 capture, 2 drain
  int  m_cnt   = 0;
  bit  m_ovf   = 0;
  bit  m_err   = 0;
  int  n_pops  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs();
    check("valid", valid_o, sb.size() != 0);
    if (sb.size() != 0) begin
      check("dat", dat_o, sb[0].data);
      check("last", last_o, sb[0].last);
    end else begin
      check("dat_empty", dat_o, 0);
      check("last_empty", last_o, 0);
    end
    check("busy", busy_o, m_state != 0);
    check("ovf", ovf_o, m_ovf);
    check("err", err_o, m_err);
  endtask

  task automatic cycle(input bit bs, input bit cv, input logic [15:0] cd,
                       input bit rdy, input bit clr);
    bit pop, popped_last, beat, drop;
    burst_start_i = bs;
    cap_valid_i   = cv;
    cap_dat_i     = cd;
    ready_i       = rdy;
    clr_i         = clr;
    check_outputs();
    pop         = (sb.size() != 0) && rdy;
    popped_last = pop ? sb[0].last : 1'b0;
    beat        = (m_state == 1) && cv;
    drop        = beat && (sb.size() == DEPTH) && !pop;
    if (pop) begin
      sb.delete(0);
      n_pops++;
    end
    if (beat && !drop) sb.push_back('{data: cd, last: (m_cnt == BURST)});
`ifdef PSRAM_CAP_PATTERN_CHECK_EN
    if (beat && (cd != 16'(m_cnt))) m_err = 1;
    else if (clr)                   m_err = 0;
`endif
    if (drop)     m_ovf = 1;
    else if (clr) m_ovf = 0;
    case (m_state)
      0: if (bs) begin m_state = 1; m_cnt = 0; end
      1: if (beat) begin
           if (m_cnt == BURST) m_state = 2;
           m_cnt++;
         end
      2: if (pop && popped_last && sb.size() == 0) m_state = 0;
      default: m_state = 0;
    endcase
    tick();
  endtask

  task automatic do_reset();
    burst_start_i = 0; cap_valid_i = 0; cap_dat_i = '0; ready_i = 0; clr_i = 0;
    rst_i = 1;
    tick();
    rst_i = 0;
    sb.delete();
    m_state = 0; m_cnt = 0; m_ovf = 0; m_err = 0;
    check_outputs();
  endtask

  typedef struct {
    bit          bs, cv;
    logic [15:0] cd;
    bit          rdy, clr;
    bit          exp_valid, exp_busy;
    logic [15:0] exp_dat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // Ignored-pulse preamble: stray beat in IDLE, burst_start_i mid-capture.
    vecs[0] = '{0, 1, 16'hAAAA, 1, 0, 0, 0, 16'h0000};
    vecs[1] = '{1, 0, 16'h0000, 1, 0, 0, 1, 16'h0000};
    vecs[2] = '{0, 1, 16'h0000, 1, 0, 1, 1, 16'h0000};
    vecs[3] = '{1, 1, 16'h0001, 1, 0, 1, 1, 16'h0001};
    vecs[4] = '{0, 0, 16'h0000, 1, 0, 0, 1, 16'h0000};

    do_reset();
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy_o, 0);

    // Basic burst with ready held high
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i <= BURST; i++) cycle(0, 1, 16'(i), 1, 0);
    check("basic_busy_before_last_pop", busy_o, 1);
    check("basic_last_on_31", last_o, 1);
    cycle(0, 0, 0, 1, 0);
    check("basic_idle_after_last_pop", busy_o, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 0);

    // Back-pressure: whole burst held, then drained
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i <= BURST; i++) cycle(0, 1, 16'(i), 0, 0);
    check("bp_no_ovf", ovf_o, 0);
    n_pops = 0;
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 1, 0);
    check("bp_pop_count", n_pops, DEPTH);
    check("bp_back_to_idle", busy_o, 0);

    // Ignored pulses, table-driven, then finish the burst through the model
    for (int i = 0; i < 5; i++) begin
      cycle(vecs[i].bs, vecs[i].cv, vecs[i].cd, vecs[i].rdy, vecs[i].clr);
      check($sformatf("vec%0d_valid", i), valid_o, vecs[i].exp_valid);
      check($sformatf("vec%0d_busy", i), busy_o, vecs[i].exp_busy);
      check($sformatf("vec%0d_dat", i), dat_o, vecs[i].exp_dat);
    end
    for (int i = 2; i <= BURST; i++) cycle(0, 1, 16'(i), 1, 0);
    check("ign_last_aligned", last_o, 1);
    check("ign_dat_31", dat_o, 31);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    check("ign_idle", busy_o, 0);

    // Mid-burst reset, then a clean burst
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 16'(i + 100), 0, 0);
    do_reset();
    check("mrst_valid", valid_o, 0);
    check("mrst_busy", busy_o, 0);
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i <= BURST; i++) cycle(0, 1, 16'(i), 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    check("mrst_idle", busy_o, 0);

    // Pattern check: beat 5 corrupted
    cycle(1, 0, 0, 1, 0);
    for (int i = 0; i <= BURST; i++) begin
      cycle(0, 1, (i == 5) ? 16'h00FF : 16'(i), 1, 0);
`ifdef PSRAM_CAP_PATTERN_CHECK_EN
      if (i == 4) check("pat_err_before", err_o, 0);
      if (i == 5) check("pat_err_after", err_o, 1);
`else
      if (i == 5) check("pat_err_tied0", err_o, 0);
`endif
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1);
    check("pat_err_cleared", err_o, 0);
    check_outputs();

    // Overflow on the shallow instance
    burst_start_i = 0; cap_valid_i = 0; ready_i = 0; clr_i = 0;
    o_rst = 1; tick(); o_rst = 0;
    check("ovf_rst_valid", o_valid, 0);
    check("ovf_rst_ovf", o_ovf, 0);
    o_bs = 1; tick(); o_bs = 0;
    for (int i = 0; i < 16; i++) begin
      o_cv = 1; o_cd = 16'h0100 + 16'(i);
      tick();
      if (i == 7) check("ovf_clear_at_8", o_ovf, 0);
      if (i == 8) check("ovf_set_at_9", o_ovf, 1);
    end
    o_cv = 0; o_rdy = 1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovf_valid%0d", k), o_valid, 1);
      check($sformatf("ovf_dat%0d", k), o_dat, 16'h0100 + 16'(k));
      check($sformatf("ovf_last%0d", k), o_last, 0);
      tick();
    end
    check("ovf_drained", o_valid, 0);
    check("ovf_sticky", o_ovf, 1);
    o_rdy = 0; o_clr = 1; tick(); o_clr = 0;
    check("ovf_cleared", o_ovf, 0);
    o_rst = 1; tick(); o_rst = 0;

    check_outputs();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/psram_read_capture.md
Name: psram_read_capture

Overview:
- Downstream stage of the PSRAM burst controller. Samples psram_dat_i on every read-data beat of a burst and stores the beats in an internal FIFO.
- Presents the stored beats to the host side as a valid/ready stream, with last-beat tagging and sticky overflow reporting.
- Frees the burst controller from host back-pressure: a whole burst (burst_size+1 beats) fits in the FIFO.

Parameters:
- data_width, 16, width of a PSRAM data word.
- fifo_depth_log2, 5, FIFO depth is 2**fifo_depth_log2 words; must satisfy 2**fifo_depth_log2 >= burst_size+1.
- burst_size, 31, beats per burst minus one; same meaning as in the burst controller.

Ports:
- clk_i  in  1  system clock; all state changes on rising edge.
- rst_i  in  1  synchronous active-high reset.
- burst_start_i  in  1  one-cycle pulse: controller has begun a read burst.
- cap_valid_i  in  1  a valid read beat is on cap_dat_i this cycle.
- cap_dat_i  in  data_width  read data from the PSRAM data bus.
- dat_o  out  data_width  head-of-FIFO word.
- valid_o  out  1  dat_o holds a valid word.
- ready_i  in  1  consumer accepts dat_o; a pop occurs when valid_o && ready_i.
- last_o  out  1  the word on dat_o is the final beat of its burst.
- busy_o  out  1  capture or drain is in progress.
- ovf_o  out  1  sticky: a beat was dropped because the FIFO was full.
- clr_i  in  1  clears ovf_o and err_o.
- err_o  out  1  pattern mismatch flag (see Optional Feature).

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, FIFO empty, beat counter=0.
- Reset values of outputs: valid_o=0, last_o=0, busy_o=0, ovf_o=0, err_o=0, dat_o=0.
- Reset mid-burst discards all stored words; no partial output survives.
- FIFO behaviour:
  - First-word-fall-through with registered storage.
  - A beat pushed at edge N is visible on dat_o/valid_o after edge N. There is no same-cycle bypass.
  - The FIFO stores data_width+1 bits per entry: data plus a last tag.
  - Occupancy counter width is fifo_depth_log2+1. Read and write pointers wrap modulo 2**fifo_depth_log2.
  - Push and pop in the same cycle: both take effect and occupancy is unchanged. This holds when full and when non-empty.
  - Push while full without a pop: the beat is dropped, ovf_o sets, and the beat counter still advances, so last-tagging stays aligned.
  - Pop while empty is impossible because valid_o=0.
- Beat counter: fifo_depth_log2+1 bits wide; counts accepted cap_valid_i beats in CAPTURE.
- State machine:
  - IDLE:
    - burst_start_i=1 -> CAPTURE; beat counter cleared.
    - cap_valid_i in IDLE is ignored: no push, no flag.
  - CAPTURE:
    - Each cap_valid_i pushes cap_dat_i. The last tag is set when the beat counter equals burst_size.
    - On that final beat -> DRAIN.
    - burst_start_i in CAPTURE is ignored.
  - DRAIN:
    - -> IDLE at the edge where the last-tagged word is popped and no other word remains.
    - burst_start_i in DRAIN is ignored.
- busy_o = (state != IDLE), registered with the state.
- last_o = last tag of the head entry, qualified by valid_o.
- ovf_o: set on a dropped beat; cleared by clr_i. If both occur in the same cycle, set wins.

Optional Feature:
- Macro: PSRAM_CAP_PATTERN_CHECK_EN.
- Defined:
  - Each captured beat is compared against the beat index, zero-extended to data_width. This matches the controller's counting write pattern.
  - On mismatch, err_o sets (sticky) and is cleared by clr_i; set wins over clear.
  - The comparison is registered, so err_o rises one cycle after the offending beat.
- Undefined: err_o is tied 0 and no comparator logic exists.

Test Plan:
- Basic burst: burst_start_i, then 32 beats of cap_dat_i=0..31 with ready_i=1 -> dat_o=0..31 in order, each one cycle after push; last_o=1 only on 31; busy_o falls after the pop of 31.
- Back-pressure: ready_i=0 during the whole 32-beat burst -> 32 words held, ovf_o=0; then ready_i=1 -> 32 pops, last_o on 31st-index word, state returns to IDLE.
- Overflow: fifo_depth_log2=3, burst_size=15, ready_i=0, 16 beats -> first 8 stored, ovf_o=1 after beat 8; no word tagged last stored; clr_i clears ovf_o.
- Ignored pulses: cap_valid_i in IDLE and burst_start_i mid-CAPTURE -> no push, no counter reset, burst completes normally.
- Mid-burst reset: rst_i after 10 beats -> valid_o=0, busy_o=0 next cycle; a new 32-beat burst is captured cleanly.
- Pattern check (macro defined): beat 5 carries 16'h00FF -> err_o=1 one cycle later and stays set until clr_i; with the macro undefined, err_o stays 0.
